tap_pipe_sum: RTL

TAP_PIPE_SUM -- requirements
Module: tap_pipe_sum

---
 rtl/tap_pipe_pkg.sv | 28 ++
 rtl/tap_pair_stage.sv | 35 +++
 rtl/tap_pipe_sum.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/tap_pipe_pkg.sv
// Shared constants and helpers for the tap_pipe_sum datapath: default
// parameters, pair/fill widths and the per-pair coefficient slice.
package tap_pipe_pkg;

   localparam int unsigned DEF_WIDTH  = 32'd8;
   localparam int unsigned DEF_TAPS   = 32'd4;
   localparam int unsigned DEF_CW     = 32'd2;
   localparam int unsigned DEF_ACC_W  = 32'd12;
   localparam int unsigned COEF_BUS_W = 32'd64;

   // Exact width of a + b + a*c for unsigned a,b of width w and c of width cw.
   function automatic int unsigned pair_width(input int unsigned width, input int unsigned cw);
      return width + cw + 32'd1;
   endfunction

   function automatic int unsigned fill_width(input int unsigned taps);
      return $clog2(taps + 32'd1);
   endfunction

   function automatic logic [COEF_BUS_W-1:0] coef_slice(input logic [COEF_BUS_W-1:0] bus,
                                                        input int unsigned k,
                                                        input int unsigned cw);
      logic [COEF_BUS_W-1:0] mask;
      mask = ~({COEF_BUS_W{1'b1}} << cw);
      return (bus >> (k * cw)) & mask;
   endfunction

endpackage

// File: rtl/tap_pair_stage.sv
// One registered pair term: even + odd + even*coef, loaded when enabled.
module tap_pair_stage
   import tap_pipe_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned CW    = DEF_CW,
   localparam int unsigned PW   = pair_width(WIDTH, CW)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic [WIDTH-1:0] tap_even_i,
   input  logic [WIDTH-1:0] tap_odd_i,
   input  logic [CW-1:0]    coef_i,
   output logic [PW-1:0]    pair_o
);

   logic [PW-1:0] pair_d;
   logic [PW-1:0] pair_q;

   always_comb begin
      pair_d = PW'(tap_even_i) + PW'(tap_odd_i) + PW'(tap_even_i) * PW'(coef_i);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pair_q <= '0;
      end else if (en_i) begin
         pair_q <= pair_d;
      end
   end

   assign pair_o = pair_q;

endmodule

// File: rtl/tap_pipe_sum.sv
// Delay line with paired coefficient taps, summed in a two-stage stallable pipeline.
// Define TAP_PIPE_SAT_EN to clamp the sum at 2^ACC_W-1 instead of wrapping.
module tap_pipe_sum
   import tap_pipe_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned TAPS  = DEF_TAPS,
   parameter int unsigned CW    = DEF_CW,
   parameter int unsigned ACC_W = DEF_ACC_W,
   localparam int unsigned NP   = TAPS / 32'd2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_data,
   input  logic [NP*CW-1:0]  coef,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_data,
   output logic              out_primed
);

   localparam int unsigned PW = pair_width(WIDTH, CW);
   localparam int unsigned FW = fill_width(TAPS);
   localparam int unsigned SW = PW + $clog2(NP) + 32'd1;

   logic             en_s;
   logic             accept_s;
   logic             pair_en_s;
   logic             primed_now_s;
   logic [WIDTH-1:0] tap_q [TAPS];
   logic [FW-1:0]    fill_q;
   logic [FW-1:0]    fill_d;
   logic             v0_q, v1_q, out_valid_q;
   logic             primed0_q, primed1_q, out_primed_q;
   logic [PW-1:0]    pair_s [NP];
   logic [SW-1:0]    sum_s;
   logic [ACC_W-1:0] out_data_d;
   logic [ACC_W-1:0] out_data_q;

   assign en_s      = !out_valid_q || out_ready;
   assign in_ready  = en_s && !rst;
   assign accept_s  = in_valid && in_ready;
   assign pair_en_s = en_s && v0_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < TAPS; i++) begin
            tap_q[i] <= '0;
         end
      end else if (accept_s) begin
         tap_q[0] <= in_data;
         for (int unsigned i = 1; i < TAPS; i++) begin
            tap_q[i] <= tap_q[i-1];
         end
      end
   end

   // Fill saturates at TAPS; the sample being accepted counts toward priming.
   always_comb begin
      if (accept_s && (fill_q != FW'(TAPS))) begin
         fill_d = fill_q + FW'(1'b1);
      end else begin
         fill_d = fill_q;
      end
   end
   assign primed_now_s = (fill_q >= FW'(TAPS - 32'd1));

   always_ff @(posedge clk) begin
      if (rst) begin
         fill_q <= '0;
      end else begin
         fill_q <= fill_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v0_q         <= 1'b0;
         v1_q         <= 1'b0;
         out_valid_q  <= 1'b0;
         primed0_q    <= 1'b0;
         primed1_q    <= 1'b0;
         out_primed_q <= 1'b0;
      end else if (en_s) begin
         v0_q         <= accept_s;
         v1_q         <= v0_q;
         out_valid_q  <= v1_q;
         primed0_q    <= accept_s && primed_now_s;
         primed1_q    <= primed0_q;
         out_primed_q <= primed1_q;
      end
   end

   for (genvar k = 0; k < NP; k++) begin : g_pair
      logic [CW-1:0] coef_k_s;
      assign coef_k_s = CW'(coef_slice(COEF_BUS_W'(coef), k, CW));

      tap_pair_stage #(
         .WIDTH (WIDTH),
         .CW    (CW)
      ) u_pair (
         .clk        (clk),
         .rst        (rst),
         .en_i       (pair_en_s),
         .tap_even_i (tap_q[2*k]),
         .tap_odd_i  (tap_q[2*k+1]),
         .coef_i     (coef_k_s),
         .pair_o     (pair_s[k])
      );
   end

   always_comb begin
      sum_s = '0;
      for (int unsigned k = 0; k < NP; k++) begin
         sum_s = sum_s + SW'(pair_s[k]);
      end
   end

`ifdef TAP_PIPE_SAT_EN
   localparam int unsigned CMP_W = (SW > ACC_W) ? SW : ACC_W;
   logic [CMP_W-1:0] sum_ext_s;
   assign sum_ext_s = CMP_W'(sum_s);

   always_comb begin
      if (sum_ext_s > CMP_W'({ACC_W{1'b1}})) begin
         out_data_d = {ACC_W{1'b1}};
      end else begin
         out_data_d = sum_ext_s[ACC_W-1:0];
      end
   end
`else
   always_comb begin
      out_data_d = ACC_W'(sum_s);
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         out_data_q <= '0;
      end else if (en_s && v1_q) begin
         out_data_q <= out_data_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_primed = out_primed_q;

endmodule
